addsub_serial: RTL



---
 rtl/addsub_pkg.sv | 20 ++
 rtl/addsub_chunk.sv | 16 +
 rtl/addsub_serial.sv | 134 +++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: state encoding and width helpers shared by the serial add/sub unit
package addsub_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam int MAX_W = 64;

   function automatic logic [MAX_W-1:0] max_pos(input int w);
      return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
   endfunction

   function automatic logic [MAX_W-1:0] min_neg(input int w);
      return MAX_W'(1) << (w - 1);
   endfunction

   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit adder exposing the carry into its top bit
module addsub_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_into_msb
);

   assign {cout, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
   assign c_into_msb = x[CHUNK-1] ^ y[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial two's-complement add/subtract with handshakes, flags and saturation
module addsub_serial
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = cnt_w(N);
   localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(max_pos(WIDTH));
   localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(min_neg(WIDTH));

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             sat_q, sat_d;
   logic             sign_q, sign_d;
   logic             c_out_q, c_out_d;
   logic             ovf_q, ovf_d;

   logic [CHUNK-1:0] s_w;
   logic             cout_w, cmsb_w, ovf_w, last_w;
   logic [WIDTH-1:0] wrapped_w;

   addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .x         (opa_q[CHUNK-1:0]),
      .y         (opb_q[CHUNK-1:0]),
      .cin       (carry_q),
      .s         (s_w),
      .cout      (cout_w),
      .c_into_msb(cmsb_w)
   );

   assign last_w    = cnt_q == CW'(N - 1);
   assign ovf_w     = cmsb_w ^ cout_w;
   assign wrapped_w = (WIDTH'(s_w) << (WIDTH - CHUNK)) | (acc_q >> CHUNK);

   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign sum       = sum_q;
   assign c_out     = c_out_q;
   assign ovf       = ovf_q;

   // Next state: latch operands on accept, consume one chunk per BUSY cycle, hold result until taken
   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      sat_d   = sat_q;
      sign_d  = sign_q;
      c_out_d = c_out_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = BUSY;
            opa_d   = a;
            opb_d   = sub ? ~b : b;
            carry_d = sub;
            sat_d   = sat;
            sign_d  = a[WIDTH-1];
            cnt_d   = '0;
            acc_d   = '0;
         end
         BUSY: begin
            opa_d   = opa_q >> CHUNK;
            opb_d   = opb_q >> CHUNK;
            carry_d = cout_w;
            acc_d   = wrapped_w;
            cnt_d   = cnt_q + 1'b1;
            if (last_w) begin
               state_d = DONE;
               sum_d   = (sat_q && ovf_w) ? (sign_q ? SAT_MIN : SAT_MAX) : wrapped_w;
               c_out_d = cout_w;
               ovf_d   = ovf_w;
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sat_q   <= 1'b0;
         sign_q  <= 1'b0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         sat_q   <= sat_d;
         sign_q  <= sign_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule
